algo_1r1w_rrarb_ctrl: RTL and testbench
=======================================

# algo_1r1w_rrarb_ctrl

Controller placed in front of a single 1R1W memory wrapper (one read port, one write port, fixed read latency). It first zero-initializes the whole array through the write port. It then round-robin arbitrates up to NUMREQ read requesters onto the single read port and passes one write requester straight through. Read responses are steered back to the granted requester with a one-hot tag pipeline matched to the wrapper's read latency.

## Interface
- NUMREQ, 4, number of read requesters
- BITREQ, 2, log2(NUMREQ)
- WIDTH, 15, data width
- NUMADDR, 256, memory depth
- BITADDR, 8, address width
- RD_LAT, 2, wrapper read latency (T1_DELAY+FLOPOUT), ≥1
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_read  in  NUMREQ  per-requester read request; held until granted
- req_adr  in  NUMREQ*BITADDR  per-requester read address, requester i at [i*BITADDR +: BITADDR]
- req_gnt  out  NUMREQ  one-hot grant, combinational, same cycle as request
- rsp_vld  out  NUMREQ  one-hot response valid
- rsp_dout  out  WIDTH  response data, shared by all requesters
- write  in  1  write request
- wr_adr  in  BITADDR  write address
- din  in  WIDTH  write data
- bw  in  WIDTH  bit-write enable
- wr_rdy  out  1  write accepted this cycle when write&wr_rdy
- init_done  out  1  array initialized, controller in RUN
- rd_err  out  1  sticky: tag pipeline and m_rd_vld disagreed
- m_read  out  1  to wrapper read
- m_rd_adr  out  BITADDR  to wrapper rd_adr
- m_rd_dout  in  WIDTH  from wrapper rd_dout
- m_rd_vld  in  1  from wrapper rd_vld
- m_write  out  1  to wrapper write
- m_wr_adr  out  BITADDR  to wrapper wr_adr
- m_din  out  WIDTH  to wrapper din
- m_bw  out  WIDTH  to wrapper bw

## Operation
- States: INIT, RUN. Reset enters INIT. Without the init feature, reset enters RUN.
- INIT: init counter `icnt` (BITADDR+1 bits) drives m_write=1, m_wr_adr=icnt, m_din=0, m_bw=all ones. Counter increments each cycle. The cycle writing NUMADDR-1 moves to RUN. In INIT: req_gnt=0, m_read=0, wr_rdy=0.
- RUN: wr_rdy=1. m_write/m_wr_adr/m_din/m_bw equal write/wr_adr/din/bw combinationally.
- Arbitration (RUN only): pointer `last` holds the last granted index. Priority order is last+1, last+2, … wrapping modulo NUMREQ. The first requesting index is granted. m_read=|req_gnt, and m_rd_adr is the granted requester's address. `last` updates on any grant. Reset value of `last` is NUMREQ-1, so requester 0 has first priority.
- Tag pipeline: RD_LAT stages of NUMREQ bits. Stage 0 loads req_gnt, and every stage shifts each cycle. rsp_vld = last stage, rsp_dout = m_rd_dout.
- rd_err is set when (|last stage) != m_rd_vld. It is cleared only by rst.
- Same-address read and write in one cycle: no bypass in the controller. The returned data is whatever the wrapper returns.

## Timing
- Reset values: req_gnt=0, rsp_vld=0, wr_rdy=0, init_done=0, rd_err=0, m_read=0, m_write=0, tag pipeline=0, icnt=0.
- Init takes exactly NUMADDR cycles after rst deasserts. init_done rises on the cycle after the last init write. The first grant is possible in that same cycle.
- A grant in cycle t gives rsp_vld in cycle t+RD_LAT.
- One grant per cycle, so sustained read throughput is 1 per cycle. Each requester with a held request is granted within NUMREQ cycles.
- rst asserted mid-INIT restarts at address 0. rst mid-RUN flushes the tag pipeline; in-flight responses are dropped, and rd_err is not set for them.
- A request deasserted before grant is legal. The arbiter never grants a non-requesting index.

## Configuration
- `ALGO_1R1W_CTRL_INIT_EN` defined: INIT state and counter present, behaviour as above.
- Not defined: no INIT state. The controller is in RUN from the first cycle after rst deasserts, init_done=1 from that cycle, and array contents are undefined.

## Structure
- Package `algo_1r1w_ctrl_pkg`: state enum (INIT, RUN), INIT_VAL (all-zero data constant).
- Sub-module `algo_rr_arb`, parameterized by NUMREQ. It takes req and an enable, returns one-hot gnt, and owns the `last` pointer. The controller instantiates it once with enable = (state==RUN).

## Test plan
- Init (macro on, NUMADDR=256): deassert rst → m_write=1 for 256 consecutive cycles with addresses 0..255, m_bw all ones, m_din=0. init_done=1 at cycle 256. A read of address 37 afterwards returns 0.
- Fairness: all 4 requesters held high in RUN → grants 0,1,2,3,0,1 on consecutive cycles. rsp_vld follows each grant RD_LAT=2 cycles later with the matching one-hot value.
- Sparse requests: only requesters 1 and 3 high → grants alternate 1,3,1,3. Requester 0 raised later is granted within 4 cycles.
- Write stall: write=1 during INIT → wr_rdy=0, and the address on m_wr_adr is the init address, not wr_adr. Same write after init_done → passes through with wr_rdy=1. A read-back of 0x5A5 at address 10 returns 0x5A5.
- Reset mid-init: rst for 1 cycle at init address 100 → init restarts at 0, and init_done is delayed to 256 cycles after that rst.
- Error: force m_rd_vld=0 when rsp_vld is nonzero → rd_err=1 the next cycle and stays 1 until rst.

Source files
------------

// File: rtl/algo_1r1w_ctrl_pkg.sv
// rtl/algo_1r1w_ctrl_pkg.sv - shared types and constants for the 1R1W round-robin controller
//
// Purpose : controller state encoding and the value written into every word
//           during array initialization.
// Contents: ctrl_state_t (INIT, RUN), INIT_VAL (all-zero data word, sliced to
//           the data width by the user; data widths up to INIT_VAL_MAXW bits).

package algo_1r1w_ctrl_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ctrl_state_t;

  localparam int INIT_VAL_MAXW = 256;
  localparam logic [INIT_VAL_MAXW-1:0] INIT_VAL = '0;

endpackage

// File: rtl/algo_rr_arb.sv
// rtl/algo_rr_arb.sv - round-robin arbiter with a last-granted pointer
//
// Purpose : grants one requester per cycle, searching from the index after
//           the last granted one and wrapping modulo NUMREQ. The grant is
//           combinational in the request cycle; the pointer moves on any grant.
// Ports   : clk, rst (sync, active high)
//           en   - arbitration allowed this cycle; no grant when low
//           req  - request vector, one bit per requester
//           gnt  - one-hot grant (all zero when nothing is granted)

module algo_rr_arb
  import algo_1r1w_ctrl_pkg::*;
#(
  parameter int NUMREQ = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUMREQ-1:0] req,
  output logic [NUMREQ-1:0] gnt
);

  localparam int BITREQ = (NUMREQ > 1) ? $clog2(NUMREQ) : 1;

  logic [BITREQ-1:0] last_q;
  logic [BITREQ-1:0] gidx;
  logic [BITREQ-1:0] idx;
  logic [BITREQ:0]   sum;
  logic              found;

  // Walk candidates last+1 .. last+NUMREQ; the first requesting one wins.
  // The extra sum bit keeps the wrap correct for non-power-of-two NUMREQ.
  always_comb begin
    gnt   = '0;
    gidx  = last_q;
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    for (int k = 1; k <= NUMREQ; k++) begin
      sum = {1'b0, last_q} + (BITREQ+1)'(k);
      if (sum >= (BITREQ+1)'(NUMREQ)) begin
        sum = sum - (BITREQ+1)'(NUMREQ);
      end
      idx = sum[BITREQ-1:0];
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        gidx     = idx;
        found    = 1'b1;
      end
    end
  end

  // Reset to the highest index so requester 0 is first in line.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= BITREQ'(NUMREQ - 1);
    end else if (found) begin
      last_q <= gidx;
    end
  end

endmodule

// File: rtl/algo_1r1w_rrarb_ctrl.sv
// rtl/algo_1r1w_rrarb_ctrl.sv - init + round-robin read arbitration in front of a 1R1W memory
//
// Purpose : optionally zero-fills the array through the write port, then
//           arbitrates NUMREQ read requesters onto the single read port and
//           passes the write requester straight through. Responses are steered
//           back with a one-hot tag pipeline RD_LAT stages deep.
// Config  : ALGO_1R1W_CTRL_INIT_EN defined -> INIT state and init counter
//           present; undefined -> controller runs from the first cycle after
//           reset and array contents are whatever the memory holds.
// Ports   : clk, rst (sync, active high)
//           req_read/req_adr -> req_gnt (combinational one-hot grant)
//           rsp_vld/rsp_dout - one-hot response valid, shared response data
//           write/wr_adr/din/bw -> wr_rdy (write accepted when both high)
//           init_done - array initialized, controller in RUN
//           rd_err    - sticky tag/rd_vld disagreement
//           m_*       - memory wrapper read/write port

module algo_1r1w_rrarb_ctrl
  import algo_1r1w_ctrl_pkg::*;
#(
  parameter int NUMREQ  = 4,
  parameter int BITREQ  = 2,
  parameter int WIDTH   = 15,
  parameter int NUMADDR = 256,
  parameter int BITADDR = 8,
  parameter int RD_LAT  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUMREQ-1:0]         req_read,
  input  logic [NUMREQ*BITADDR-1:0] req_adr,
  output logic [NUMREQ-1:0]         req_gnt,
  output logic [NUMREQ-1:0]         rsp_vld,
  output logic [WIDTH-1:0]          rsp_dout,
  input  logic                      write,
  input  logic [BITADDR-1:0]        wr_adr,
  input  logic [WIDTH-1:0]          din,
  input  logic [WIDTH-1:0]          bw,
  output logic                      wr_rdy,
  output logic                      init_done,
  output logic                      rd_err,
  output logic                      m_read,
  output logic [BITADDR-1:0]        m_rd_adr,
  input  logic [WIDTH-1:0]          m_rd_dout,
  input  logic                      m_rd_vld,
  output logic                      m_write,
  output logic [BITADDR-1:0]        m_wr_adr,
  output logic [WIDTH-1:0]          m_din,
  output logic [WIDTH-1:0]          m_bw
);

  ctrl_state_t state_q, state_n;
  logic        run_en;

`ifdef ALGO_1R1W_CTRL_INIT_EN
  localparam logic [BITADDR:0] LAST_ADR = (BITADDR+1)'(NUMADDR - 1);
  logic [BITADDR:0] icnt_q, icnt_n;
`endif

  // Gating with rst keeps grants and writes off during the reset cycle even
  // though the state register only changes at the edge.
  assign run_en    = (state_q == RUN) && !rst;
  assign init_done = run_en;

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef ALGO_1R1W_CTRL_INIT_EN
      state_q <= INIT;
      icnt_q  <= '0;
`else
      state_q <= RUN;
`endif
    end else begin
      state_q <= state_n;
`ifdef ALGO_1R1W_CTRL_INIT_EN
      icnt_q  <= icnt_n;
`endif
    end
  end

  always_comb begin
    state_n  = state_q;
`ifdef ALGO_1R1W_CTRL_INIT_EN
    icnt_n   = icnt_q;
`endif
    wr_rdy   = 1'b0;
    m_write  = 1'b0;
    m_wr_adr = wr_adr;
    m_din    = din;
    m_bw     = bw;
    case (state_q)
      INIT: begin
`ifdef ALGO_1R1W_CTRL_INIT_EN
        // The write port belongs to the init sequence; the user write stalls.
        icnt_n = icnt_q + (BITADDR+1)'(1);
        if (icnt_q == LAST_ADR) begin
          state_n = RUN;
        end
        if (!rst) begin
          m_write  = 1'b1;
          m_wr_adr = icnt_q[BITADDR-1:0];
          m_din    = INIT_VAL[WIDTH-1:0];
          m_bw     = '1;
        end
`else
        state_n = RUN;
`endif
      end
      RUN: begin
        if (!rst) begin
          wr_rdy  = 1'b1;
          m_write = write;
        end
      end
      default: state_n = RUN;
    endcase
  end

  // ---------------------------------------------------------------- read arbitration
  algo_rr_arb #(
    .NUMREQ (NUMREQ)
  ) u_arb (
    .clk (clk),
    .rst (rst),
    .en  (run_en),
    .req (req_read),
    .gnt (req_gnt)
  );

  logic [BITREQ-1:0] gnt_idx;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUMREQ; i++) begin
      if (req_gnt[i]) begin
        gnt_idx = BITREQ'(i);
      end
    end
  end

  always_comb begin
    m_rd_adr = '0;
    for (int i = 0; i < NUMREQ; i++) begin
      if (gnt_idx == BITREQ'(i)) begin
        m_rd_adr = req_adr[i*BITADDR +: BITADDR];
      end
    end
  end

  assign m_read = |req_gnt;

  // ---------------------------------------------------------------- response steering
  logic [NUMREQ-1:0] tag_q [RD_LAT];
  logic [RD_LAT-1:0] blank_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= req_gnt;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign rsp_vld  = tag_q[RD_LAT-1];
  assign rsp_dout = m_rd_dout;

  // Reads issued just before a reset still come back from the memory while
  // the tag pipeline is already flushed. The first RD_LAT cycles after reset
  // skip the consistency check so those dropped responses raise no error; no
  // read issued after reset can return inside that window.
  always_ff @(posedge clk) begin
    if (rst) begin
      blank_q <= '1;
      rd_err  <= 1'b0;
    end else begin
      blank_q <= blank_q >> 1;
      if (!blank_q[0] && ((|tag_q[RD_LAT-1]) != m_rd_vld)) begin
        rd_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_algo_1r1w_rrarb_ctrl.sv
// tb/tb_algo_1r1w_rrarb_ctrl.sv - self-checking bench for algo_1r1w_rrarb_ctrl

module tb_algo_1r1w_rrarb_ctrl;

  localparam int NUMREQ  = 4;
  localparam int BITREQ  = 2;
  localparam int WIDTH   = 15;
  localparam int NUMADDR = 256;
  localparam int BITADDR = 8;
  localparam int RD_LAT  = 2;
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  logic                      clk;
  logic                      rst;
  logic [NUMREQ-1:0]         req_read;
  logic [NUMREQ*BITADDR-1:0] req_adr;
  logic [NUMREQ-1:0]         req_gnt;
  logic [NUMREQ-1:0]         rsp_vld;
  logic [WIDTH-1:0]          rsp_dout;
  logic                      write;
  logic [BITADDR-1:0]        wr_adr;
  logic [WIDTH-1:0]          din;
  logic [WIDTH-1:0]          bw;
  logic                      wr_rdy;
  logic                      init_done;
  logic                      rd_err;
  logic                      m_read;
  logic [BITADDR-1:0]        m_rd_adr;
  logic [WIDTH-1:0]          m_rd_dout;
  logic                      m_rd_vld;
  logic                      m_write;
  logic [BITADDR-1:0]        m_wr_adr;
  logic [WIDTH-1:0]          m_din;
  logic [WIDTH-1:0]          m_bw;
  logic                      kill_vld;

  int n_tests = 0;
  int n_fail  = 0;

  algo_1r1w_rrarb_ctrl #(
    .NUMREQ(NUMREQ), .BITREQ(BITREQ), .WIDTH(WIDTH),
    .NUMADDR(NUMADDR), .BITADDR(BITADDR), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_read(req_read), .req_adr(req_adr), .req_gnt(req_gnt),
    .rsp_vld(rsp_vld), .rsp_dout(rsp_dout),
    .write(write), .wr_adr(wr_adr), .din(din), .bw(bw), .wr_rdy(wr_rdy),
    .init_done(init_done), .rd_err(rd_err),
    .m_read(m_read), .m_rd_adr(m_rd_adr), .m_rd_dout(m_rd_dout), .m_rd_vld(m_rd_vld),
    .m_write(m_write), .m_wr_adr(m_wr_adr), .m_din(m_din), .m_bw(m_bw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory wrapper: fixed-latency read (old data on same-cycle write), bit-write.
  logic [WIDTH-1:0] wmem [NUMADDR] = '{default: '0};
  logic             rp_v [RD_LAT]  = '{default: 1'b0};
  logic [WIDTH-1:0] rp_d [RD_LAT]  = '{default: '0};

  always @(posedge clk) begin
    rp_v[0] <= m_read;
    rp_d[0] <= wmem[m_rd_adr];
    for (int i = 1; i < RD_LAT; i++) begin
      rp_v[i] <= rp_v[i-1];
      rp_d[i] <= rp_d[i-1];
    end
    if (m_write) wmem[m_wr_adr] <= (wmem[m_wr_adr] & ~m_bw) | (m_din & m_bw);
  end

  assign m_rd_vld  = rp_v[RD_LAT-1] & ~kill_vld;
  assign m_rd_dout = rp_d[RD_LAT-1];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration: among requesters, the one at the smallest forward
  // distance from the last granted index wins.
  function automatic int rr_pick(input logic [NUMREQ-1:0] r, input int last);
    int best  = -1;
    int bestd = NUMREQ + 1;
    for (int i = 0; i < NUMREQ; i++) begin
      if (r[i]) begin
        int d;
        d = (i - last - 1 + 2 * NUMREQ) % NUMREQ;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [BITADDR-1:0] adr_of(input int p);
    return req_adr[p*BITADDR +: BITADDR];
  endfunction

`ifdef ALGO_1R1W_CTRL_INIT_EN
  // Checks ncyc init cycles starting at address 0 while a user write and all
  // read requests are pending.
  task automatic init_run(input int ncyc);
    req_read = '1;
    write    = 1'b1;
    wr_adr   = 8'h33;
    din      = 15'h1234;
    bw       = 15'h00f0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      chk("init_wr", {m_write, m_wr_adr, m_din, m_bw}, {1'b1, 8'(c), {WIDTH{1'b0}}, ONES});
      chk("init_block", {wr_rdy, init_done, req_gnt, m_read, rsp_vld, rd_err}, '0);
      step();
    end
  endtask
`endif

  typedef struct {
    logic [NUMREQ-1:0] req;
    logic              wr;
    logic [NUMREQ-1:0] gnt;
    logic [NUMREQ-1:0] rsp;
    logic [WIDTH-1:0]  dout;
  } vec_t;

  vec_t tbl [14];

  logic [WIDTH-1:0]  sh [NUMADDR];
  logic [NUMREQ-1:0] q_g [$];
  logic [WIDTH-1:0]  q_d [$];
  int                m_last;

  initial begin
    // all held, then 1&3 only, then 0 joins
    tbl[0]  = '{4'hF, 1'b1, 4'h1, 4'h0, 15'h000};
    tbl[1]  = '{4'hF, 1'b0, 4'h2, 4'h0, 15'h000};
    tbl[2]  = '{4'hF, 1'b0, 4'h4, 4'h1, 15'h000};
    tbl[3]  = '{4'hF, 1'b0, 4'h8, 4'h2, 15'h5A5};
    tbl[4]  = '{4'hF, 1'b0, 4'h1, 4'h4, 15'h000};
    tbl[5]  = '{4'hF, 1'b0, 4'h2, 4'h8, 15'h000};
    tbl[6]  = '{4'hA, 1'b0, 4'h8, 4'h1, 15'h000};
    tbl[7]  = '{4'hA, 1'b0, 4'h2, 4'h2, 15'h5A5};
    tbl[8]  = '{4'hA, 1'b0, 4'h8, 4'h8, 15'h000};
    tbl[9]  = '{4'hA, 1'b0, 4'h2, 4'h2, 15'h5A5};
    tbl[10] = '{4'hB, 1'b0, 4'h8, 4'h8, 15'h000};
    tbl[11] = '{4'hB, 1'b0, 4'h1, 4'h2, 15'h5A5};
    tbl[12] = '{4'h0, 1'b0, 4'h0, 4'h8, 15'h000};
    tbl[13] = '{4'h0, 1'b0, 4'h0, 4'h1, 15'h000};

    rst      = 1'b1;
    kill_vld = 1'b0;
    req_read = '1;
    req_adr  = {8'd200, 8'd150, 8'd10, 8'd37};
    write    = 1'b1;
    wr_adr   = 8'h33;
    din      = 15'h1234;
    bw       = ONES;

    // ---- reset state
    step();
    @(negedge clk);
    chk("reset_outs", {req_gnt, rsp_vld, wr_rdy, init_done, rd_err, m_read, m_write}, '0);
    step();
    rst = 1'b0;

`ifdef ALGO_1R1W_CTRL_INIT_EN
    // ---- init, one-cycle reset at address 100, then full init
    init_run(100);
    rst = 1'b1;
    @(negedge clk);
    chk("init_rst_block", {req_gnt, m_write, wr_rdy, init_done}, '0);
    step();
    rst = 1'b0;
    init_run(NUMADDR);
`endif

    // ---- table: fairness, sparse requests, write pass-through, read-back
    for (int r = 0; r < 14; r++) begin
      req_read = tbl[r].req;
      write    = tbl[r].wr;
      wr_adr   = 8'd10;
      din      = 15'h5A5;
      bw       = ONES;
      @(negedge clk);
      chk($sformatf("tbl%0d_gnt", r), req_gnt, tbl[r].gnt);
      chk($sformatf("tbl%0d_rsp", r), rsp_vld, tbl[r].rsp);
      if (tbl[r].rsp != 0) chk($sformatf("tbl%0d_dout", r), rsp_dout, tbl[r].dout);
      if (tbl[r].gnt != 0) chk($sformatf("tbl%0d_radr", r), m_rd_adr, adr_of($clog2(tbl[r].gnt)));
      chk($sformatf("tbl%0d_ctl", r), {init_done, wr_rdy, m_write, m_read, rd_err},
          {1'b1, 1'b1, tbl[r].wr, |tbl[r].gnt, 1'b0});
      if (tbl[r].wr) chk("tbl_wpass", {m_wr_adr, m_din, m_bw}, {8'd10, 15'h5A5, ONES});
      step();
    end

    // ---- randomized run against the reference model
    for (int a = 0; a < NUMADDR; a++) sh[a] = '0;
    sh[10] = 15'h5A5;
    m_last = 0;
    for (int i = 0; i < RD_LAT; i++) begin
      q_g.push_back('0);
      q_d.push_back('0);
    end
    for (int n = 0; n < 2000; n++) begin
      int p;
      logic [NUMREQ-1:0] eg, er;
      logic [WIDTH-1:0]  ed, erd;
      req_read = NUMREQ'($urandom);
      for (int i = 0; i < NUMREQ; i++) req_adr[i*BITADDR +: BITADDR] = BITADDR'($urandom_range(0, 15));
      write  = 1'($urandom);
      wr_adr = BITADDR'($urandom_range(0, 15));
      din    = WIDTH'($urandom);
      bw     = WIDTH'($urandom);
      @(negedge clk);
      p  = rr_pick(req_read, m_last);
      eg = '0;
      ed = '0;
      if (p >= 0) begin
        eg[p]  = 1'b1;
        ed     = sh[adr_of(p)];
        m_last = p;
      end
      q_g.push_back(eg);
      q_d.push_back(ed);
      er  = q_g.pop_front();
      erd = q_d.pop_front();
      chk("rnd_gnt", req_gnt, eg);
      chk("rnd_rsp", rsp_vld, er);
      if (er != 0) chk("rnd_dout", rsp_dout, erd);
      if (eg != 0) chk("rnd_radr", m_rd_adr, adr_of(p));
      chk("rnd_wpass", {m_write, m_wr_adr, m_din, m_bw, wr_rdy, m_read, rd_err},
          {write, wr_adr, din, bw, 1'b1, |eg, 1'b0});
      if (write) sh[wr_adr] = (sh[wr_adr] & ~bw) | (din & bw);
      step();
    end

    // ---- reset mid-run with reads in flight
    req_read = '1;
    write    = 1'b0;
    step();
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("runrst_block", {req_gnt, m_read, m_write, wr_rdy, init_done}, '0);
    step();
    rst      = 1'b0;
    req_read = '0;
`ifdef ALGO_1R1W_CTRL_INIT_EN
    init_run(NUMADDR);
    req_read = '0;
    write    = 1'b0;
`else
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("runrst_flush", {rsp_vld, rd_err, init_done}, {{NUMREQ{1'b0}}, 1'b0, 1'b1});
      step();
    end
`endif

    // ---- response valid suppressed -> sticky rd_err
    req_adr  = {8'd200, 8'd150, 8'd10, 8'd37};
    req_read = 4'h4;
    @(negedge clk);
    chk("err_gnt", req_gnt, 4'h4);
    step();
    req_read = '0;
    kill_vld = 1'b1;
    step();
    @(negedge clk);
    chk("err_rsp", {rsp_vld, rd_err}, {4'h4, 1'b0});
    step();
    kill_vld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("err_sticky", rd_err, 1'b1);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("err_cleared", rd_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
